// File: rtl/sfu_acc_ctrl_pkg.sv
// Shared types and constants for the SFU accumulate/ReLU sequencer.
package sfu_acc_ctrl_pkg;

   localparam int ADDR_BW = 11;
   localparam int TAP_BW  = 4;

   localparam logic SFU_MODE_ACC  = 1'b1;
   localparam logic SFU_MODE_RELU = 1'b0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLR   = 3'd1,
      ST_RD    = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RELU  = 3'd4,
      ST_WR    = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

endpackage

// File: rtl/sfu_acc_ctrl_addr_gen.sv
// Running psum/output address counters. Psum addresses advance by the row stride per tap,
// so base + k*num_out + o is formed without a multiplier; all arithmetic wraps.
module sfu_acc_ctrl_addr_gen
   import sfu_acc_ctrl_pkg::*;
#(
   parameter int addr_bw = ADDR_BW
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step_tap,
   input  logic               step_out,
   input  logic [addr_bw-1:0] psum_base,
   input  logic [addr_bw-1:0] out_base,
   input  logic [addr_bw-1:0] stride,
   output logic [addr_bw-1:0] psum_ptr,
   output logic [addr_bw-1:0] out_ptr
);

   logic [addr_bw-1:0] row_base_reg;
   logic [addr_bw-1:0] stride_reg;
   logic [addr_bw-1:0] psum_ptr_reg;
   logic [addr_bw-1:0] out_ptr_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         row_base_reg <= '0;
         stride_reg   <= '0;
         psum_ptr_reg <= '0;
         out_ptr_reg  <= '0;
      end else if (load) begin
         row_base_reg <= psum_base;
         psum_ptr_reg <= psum_base;
         out_ptr_reg  <= out_base;
         stride_reg   <= stride;
      end else if (step_out) begin
         // next output row restarts its tap walk one column further on
         row_base_reg <= row_base_reg + addr_bw'(1);
         psum_ptr_reg <= row_base_reg + addr_bw'(1);
         out_ptr_reg  <= out_ptr_reg + addr_bw'(1);
      end else if (step_tap) begin
         psum_ptr_reg <= psum_ptr_reg + stride_reg;
      end
   end

   assign psum_ptr = psum_ptr_reg;
   assign out_ptr  = out_ptr_reg;

endmodule

// File: rtl/sfu_acc_ctrl.sv
// Output-stage sequencer: per output row, clear the SFU, accumulate cfg_taps psum rows,
// apply one ReLU cycle and write the result row to output SRAM.
module sfu_acc_ctrl
   import sfu_acc_ctrl_pkg::*;
#(
   parameter int addr_bw = ADDR_BW,
   parameter int tap_bw  = TAP_BW
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [tap_bw-1:0]  cfg_taps,
   input  logic [addr_bw-1:0] cfg_num_out,
   input  logic [addr_bw-1:0] cfg_psum_base,
   input  logic [addr_bw-1:0] cfg_out_base,
   output logic               sfu_clr,
   output logic               sfu_mode,
   output logic               psum_cen,
   output logic [addr_bw-1:0] psum_addr,
   output logic               out_cen,
   output logic               out_wen,
   output logic [addr_bw-1:0] out_addr,
   output logic               busy,
   output logic               done
);

   state_t             state_reg;
   logic [tap_bw-1:0]  taps_reg;
   logic [tap_bw-1:0]  tap_reg;
   logic [addr_bw-1:0] num_out_reg;
   logic [addr_bw-1:0] row_reg;
   logic               load;
   logic               step_tap;
   logic               step_out;
   logic               last_tap;
   logic               last_row;
   logic [addr_bw-1:0] psum_ptr;
   logic [addr_bw-1:0] out_ptr;

   assign last_tap = (tap_reg == taps_reg - tap_bw'(1));
   assign last_row = (row_reg == num_out_reg - addr_bw'(1));

   // The pointer advances whenever its current value is captured into psum_addr.
   always_comb begin
      load     = 1'b0;
      step_tap = 1'b0;
      step_out = 1'b0;
      case (state_reg)
         ST_IDLE: load     = start;
         ST_CLR:  step_tap = 1'b1;
         ST_RD:   step_tap = !last_tap;
         ST_WR:   step_out = !last_row;
         default: ;
      endcase
   end

   sfu_acc_ctrl_addr_gen #(.addr_bw(addr_bw)) u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .step_tap  (step_tap),
      .step_out  (step_out),
      .psum_base (cfg_psum_base),
      .out_base  (cfg_out_base),
      .stride    (cfg_num_out),
      .psum_ptr  (psum_ptr),
      .out_ptr   (out_ptr)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         taps_reg    <= '0;
         tap_reg     <= '0;
         num_out_reg <= '0;
         row_reg     <= '0;
         sfu_clr     <= 1'b0;
         sfu_mode    <= SFU_MODE_RELU;
         psum_cen    <= 1'b1;
         psum_addr   <= '0;
         out_cen     <= 1'b1;
         out_wen     <= 1'b1;
         out_addr    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         sfu_clr  <= 1'b0;
         sfu_mode <= SFU_MODE_RELU;
         psum_cen <= 1'b1;
         out_cen  <= 1'b1;
         out_wen  <= 1'b1;
         done     <= 1'b0;
         if (abort && state_reg != ST_IDLE) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  if (start && !abort) begin
                     taps_reg    <= cfg_taps;
                     num_out_reg <= cfg_num_out;
                     tap_reg     <= '0;
                     row_reg     <= '0;
                     if (cfg_taps == '0 || cfg_num_out == '0) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                     end else begin
                        state_reg <= ST_CLR;
                        sfu_clr   <= 1'b1;
                        busy      <= 1'b1;
                     end
                  end
               end
               ST_CLR: begin
                  // first read cycle has no data yet, so the SFU idles in ReLU on zero
                  state_reg <= ST_RD;
                  tap_reg   <= '0;
                  psum_cen  <= 1'b0;
                  psum_addr <= psum_ptr;
               end
               ST_RD: begin
                  sfu_mode <= SFU_MODE_ACC;
                  if (last_tap) begin
                     state_reg <= ST_DRAIN;
                  end else begin
                     tap_reg   <= tap_reg + tap_bw'(1);
                     psum_cen  <= 1'b0;
                     psum_addr <= psum_ptr;
                  end
               end
               ST_DRAIN: state_reg <= ST_RELU;
               ST_RELU: begin
                  state_reg <= ST_WR;
                  out_cen   <= 1'b0;
                  out_wen   <= 1'b0;
                  out_addr  <= out_ptr;
               end
               ST_WR: begin
                  if (last_row) begin
                     state_reg <= ST_DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                  end else begin
                     state_reg <= ST_CLR;
                     row_reg   <= row_reg + addr_bw'(1);
                     sfu_clr   <= 1'b1;
                  end
               end
               ST_DONE: state_reg <= ST_IDLE;
               default: state_reg <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sfu_acc_ctrl.sv
// Bench for sfu_acc_ctrl: psum/output SRAMs and an SFU model sit in the loop; a
// plain-arithmetic reference predicts addresses, written values and run length.
module tb_sfu_acc_ctrl;
   import sfu_acc_ctrl_pkg::*;

   localparam int AW    = 11;
   localparam int TW    = 4;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [TW-1:0] cfg_taps = '0;
   logic [AW-1:0] cfg_num_out = '0;
   logic [AW-1:0] cfg_psum_base = '0;
   logic [AW-1:0] cfg_out_base = '0;
   logic          sfu_clr, sfu_mode, psum_cen, out_cen, out_wen, busy, done;
   logic [AW-1:0] psum_addr, out_addr;

   always #5 clk = ~clk;

   sfu_acc_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .cfg_taps      (cfg_taps),
      .cfg_num_out   (cfg_num_out),
      .cfg_psum_base (cfg_psum_base),
      .cfg_out_base  (cfg_out_base),
      .sfu_clr       (sfu_clr),
      .sfu_mode      (sfu_mode),
      .psum_cen      (psum_cen),
      .psum_addr     (psum_addr),
      .out_cen       (out_cen),
      .out_wen       (out_wen),
      .out_addr      (out_addr),
      .busy          (busy),
      .done          (done)
   );

   // SRAMs with 1-cycle read latency and the accumulate/ReLU unit
   logic signed [15:0] psum_mem [DEPTH];
   logic signed [15:0] out_mem [DEPTH];
   logic signed [15:0] psum_q;
   logic signed [15:0] acc;

   always @(posedge clk) begin
      if (!psum_cen) psum_q <= psum_mem[psum_addr];
      if (!out_cen && !out_wen) out_mem[out_addr] <= acc;
      if (reset || sfu_clr) acc <= '0;
      else if (sfu_mode) acc <= acc + psum_q;
      else if (acc < 0) acc <= '0;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int rd_q[$], wr_q[$];
   int done_at, busy_cnt;
   logic [6:0] probe_ctl;
   logic [AW-1:0] probe_paddr, probe_oaddr;
   int exp_rd[$], exp_wr[$], exp_val[$];
   int exp_lat;

   task automatic fill_psum();
      for (int a = 0; a < DEPTH; a++) begin
         int v;
         v = int'($urandom_range(0, 200)) - 100;
         psum_mem[a] = 16'(v);
      end
   endtask

   // Reference: output row o sums psum[(pb + k*num + o) mod DEPTH] over k, then ReLU.
   task automatic build_model(input int taps, input int num, input int pb, input int ob);
      exp_rd.delete(); exp_wr.delete(); exp_val.delete();
      if (taps == 0 || num == 0) begin
         exp_lat = 1;
      end else begin
         exp_lat = num * (taps + 4) + 1;
         for (int o = 0; o < num; o++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < taps; k++) begin
               int a;
               a = (pb + k * num + o) % DEPTH;
               exp_rd.push_back(a);
               sum += int'(psum_mem[a]);
            end
            exp_wr.push_back((ob + o) % DEPTH);
            exp_val.push_back(sum < 0 ? 0 : sum);
         end
      end
   endtask

   // Starts one job and records activity per cycle until done or max_cyc cycles.
   task automatic run_job(input int taps, input int num, input int pb, input int ob,
                          input int abort_at, input int restart_at, input int reset_at,
                          input int max_cyc);
      rd_q.delete(); wr_q.delete();
      done_at = -1; busy_cnt = 0;
      @(negedge clk);
      cfg_taps = TW'(taps); cfg_num_out = AW'(num);
      cfg_psum_base = AW'(pb); cfg_out_base = AW'(ob);
      start = 1'b1;
      for (int n = 1; n <= max_cyc; n++) begin
         @(negedge clk);
         start = 1'b0; abort = 1'b0; reset = 1'b0;
         if (n == 1) begin
            cfg_taps = TW'($urandom); cfg_num_out = AW'($urandom);
            cfg_psum_base = AW'($urandom); cfg_out_base = AW'($urandom);
         end
         if (!psum_cen) rd_q.push_back(int'(psum_addr));
         if (!out_cen && !out_wen) wr_q.push_back(int'(out_addr));
         if (busy) busy_cnt++;
         if (n == abort_at + 1 || n == reset_at + 1) begin
            probe_ctl = {sfu_clr, sfu_mode, psum_cen, out_cen, out_wen, busy, done};
            probe_paddr = psum_addr;
            probe_oaddr = out_addr;
         end
         if (done) begin
            done_at = n;
            break;
         end
         if (n == abort_at) abort = 1'b1;
         if (n == restart_at) begin
            start = 1'b1;
            cfg_taps = TW'($urandom_range(1, 15)); cfg_num_out = AW'($urandom_range(1, 9));
         end
         if (n == reset_at) reset = 1'b1;
      end
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      $display("job taps=%0d num=%0d pb=%0d ob=%0d: done_at=%0d reads=%0d writes=%0d busy_cycles=%0d",
               taps, num, pb, ob, done_at, rd_q.size(), wr_q.size(), busy_cnt);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({sfu_clr, sfu_mode, psum_cen, out_cen, out_wen, busy, done} !== 7'b0011100) begin
         n_bad++;
         $display("FAIL reset_ctl: got %b expected 0011100", {sfu_clr, sfu_mode, psum_cen, out_cen, out_wen, busy, done});
      end
      n_cmp++;
      if (psum_addr !== '0) begin n_bad++; $display("FAIL reset_psum_addr: got %0d expected 0", psum_addr); end
      n_cmp++;
      if (out_addr !== '0) begin n_bad++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_runs();
      int cfg [8][4];
      cfg[0] = '{3, 2, 0, 100};
      cfg[1] = '{2, 2, 2046, 2040};
      for (int i = 2; i < 8; i++)
         cfg[i] = '{int'($urandom_range(1, 15)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047))};
      for (int i = 0; i < 8; i++) begin
         fill_psum();
         if (i == 0) begin
            psum_mem[0] = -16'sd5; psum_mem[2] = 16'sd2;  psum_mem[4] = 16'sd1;
            psum_mem[1] = 16'sd7;  psum_mem[3] = -16'sd3; psum_mem[5] = 16'sd1;
         end
         build_model(cfg[i][0], cfg[i][1], cfg[i][2], cfg[i][3]);
         run_job(cfg[i][0], cfg[i][1], cfg[i][2], cfg[i][3], -1, -1, -1, exp_lat + 4);
         n_cmp++;
         if (done_at !== exp_lat) begin n_bad++; $display("FAIL runs_latency[%0d]: got %0d expected %0d", i, done_at, exp_lat); end
         n_cmp++;
         if (busy_cnt !== exp_lat - 1) begin n_bad++; $display("FAIL runs_busy[%0d]: got %0d expected %0d", i, busy_cnt, exp_lat - 1); end
         n_cmp++;
         if (rd_q.size() !== exp_rd.size()) begin n_bad++; $display("FAIL runs_nreads[%0d]: got %0d expected %0d", i, rd_q.size(), exp_rd.size()); end
         for (int j = 0; j < exp_rd.size(); j++) begin
            int act;
            act = (j < rd_q.size()) ? rd_q[j] : -1;
            n_cmp++;
            if (act !== exp_rd[j]) begin n_bad++; $display("FAIL runs_raddr[%0d][%0d]: got %0d expected %0d", i, j, act, exp_rd[j]); end
         end
         n_cmp++;
         if (wr_q.size() !== exp_wr.size()) begin n_bad++; $display("FAIL runs_nwrites[%0d]: got %0d expected %0d", i, wr_q.size(), exp_wr.size()); end
         for (int j = 0; j < exp_wr.size(); j++) begin
            int act;
            act = (j < wr_q.size()) ? wr_q[j] : -1;
            n_cmp++;
            if (act !== exp_wr[j]) begin n_bad++; $display("FAIL runs_waddr[%0d][%0d]: got %0d expected %0d", i, j, act, exp_wr[j]); end
            n_cmp++;
            if (int'(out_mem[exp_wr[j]]) !== exp_val[j]) begin
               n_bad++;
               $display("FAIL runs_wdata[%0d][%0d]: got %0d expected %0d", i, j, out_mem[exp_wr[j]], exp_val[j]);
            end
         end
         if (i == 0) begin
            n_cmp++;
            if (out_mem[100] !== 16'sd0) begin n_bad++; $display("FAIL relu_neg_col: got %0d expected 0", out_mem[100]); end
            n_cmp++;
            if (out_mem[101] !== 16'sd5) begin n_bad++; $display("FAIL relu_pos_col: got %0d expected 5", out_mem[101]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int t, m;
      fill_psum();
      build_model(3, 2, 0, 100);
      run_job(3, 2, 0, 100, -1, 5, -1, 24);
      n_cmp++;
      if (done_at !== 15) begin n_bad++; $display("FAIL restart_latency: got %0d expected 15", done_at); end
      n_cmp++;
      if (rd_q != exp_rd) begin n_bad++; $display("FAIL restart_reads: got %0d reads expected %0d matching", rd_q.size(), exp_rd.size()); end
      n_cmp++;
      if (wr_q != exp_wr) begin n_bad++; $display("FAIL restart_writes: got %0d writes expected %0d matching", wr_q.size(), exp_wr.size()); end
      t = int'($urandom_range(1, 15));
      m = int'($urandom_range(1, 5));
      build_model(t, m, 7, 300);
      run_job(t, m, 7, 300, -1, -1, -1, exp_lat + 4);
      n_cmp++;
      if (done_at !== exp_lat) begin n_bad++; $display("FAIL b2b_latency: got %0d expected %0d", done_at, exp_lat); end
      n_cmp++;
      if (rd_q != exp_rd) begin n_bad++; $display("FAIL b2b_reads: got %0d reads expected %0d matching", rd_q.size(), exp_rd.size()); end
   endtask

   task automatic test_abort();
      fill_psum();
      build_model(3, 2, 0, 100);
      run_job(3, 2, 0, 100, 3, -1, -1, 12);
      n_cmp++;
      if (done_at !== -1) begin n_bad++; $display("FAIL abort_done: got done at %0d expected none", done_at); end
      n_cmp++;
      if (wr_q.size() !== 0) begin n_bad++; $display("FAIL abort_writes: got %0d expected 0", wr_q.size()); end
      n_cmp++;
      if (rd_q.size() !== 2 || rd_q[0] !== 0 || rd_q[1] !== 2) begin
         n_bad++; $display("FAIL abort_reads: got %0d reads expected 2 (0,2)", rd_q.size());
      end
      n_cmp++;
      if (probe_ctl[4:0] !== 5'b11100) begin n_bad++; $display("FAIL abort_outputs: got %b expected 11100", probe_ctl[4:0]); end
      // abort together with start while idle: the start is dropped
      @(negedge clk);
      cfg_taps = 4'd3; cfg_num_out = 11'd2; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      n_cmp++;
      if ({busy, sfu_clr, done} !== 3'b000) begin n_bad++; $display("FAIL abort_beats_start: got %b expected 000", {busy, sfu_clr, done}); end
      build_model(3, 2, 0, 100);
      run_job(3, 2, 0, 100, -1, -1, -1, 20);
      n_cmp++;
      if (done_at !== 15) begin n_bad++; $display("FAIL abort_rerun_latency: got %0d expected 15", done_at); end
      n_cmp++;
      if (wr_q != exp_wr) begin n_bad++; $display("FAIL abort_rerun_writes: got %0d writes expected 2", wr_q.size()); end
   endtask

   task automatic test_zero_taps();
      int zc [2][2];
      zc[0] = '{0, 3};
      zc[1] = '{5, 0};
      for (int i = 0; i < 2; i++) begin
         run_job(zc[i][0], zc[i][1], 5, 7, -1, -1, -1, 6);
         n_cmp++;
         if (done_at !== 1) begin n_bad++; $display("FAIL zero_latency[%0d]: got %0d expected 1", i, done_at); end
         n_cmp++;
         if (rd_q.size() + wr_q.size() !== 0) begin
            n_bad++; $display("FAIL zero_sram_access[%0d]: got %0d expected 0", i, rd_q.size() + wr_q.size());
         end
         n_cmp++;
         if (busy_cnt !== 0) begin n_bad++; $display("FAIL zero_busy[%0d]: got %0d expected 0", i, busy_cnt); end
      end
   endtask

   task automatic test_reset_in_wr();
      fill_psum();
      // taps=2: CLR, RD, RD, DRAIN, RELU, then WR in cycle 6
      run_job(2, 2, 2046, 10, -1, -1, 6, 12);
      n_cmp++;
      if (wr_q.size() !== 1) begin n_bad++; $display("FAIL rst_wr_seen: got %0d expected 1", wr_q.size()); end
      n_cmp++;
      if (rd_q.size() !== 2 || rd_q[0] !== 2046 || rd_q[1] !== 0) begin
         n_bad++; $display("FAIL rst_reads: got %0d reads expected 2 (2046,0)", rd_q.size());
      end
      n_cmp++;
      if (probe_ctl !== 7'b0011100) begin n_bad++; $display("FAIL rst_outputs: got %b expected 0011100", probe_ctl); end
      n_cmp++;
      if ({probe_paddr, probe_oaddr} !== '0) begin n_bad++; $display("FAIL rst_addrs: got %0d/%0d expected 0/0", probe_paddr, probe_oaddr); end
      n_cmp++;
      if (done_at !== -1) begin n_bad++; $display("FAIL rst_done: got done at %0d expected none", done_at); end
   endtask

   initial begin
      test_reset();
      test_runs();
      test_back_to_back();
      test_abort();
      test_zero_taps();
      test_reset_in_wr();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
